// File: rtl/cache_fill_arbiter_pkg.sv
// Shared types and constants for the cache fill arbiter: FSM states,
// block geometry and the fill target encoding.
package cache_fill_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } fill_state_t;

    localparam int          WORDS_PER_BLOCK   = 8;
    localparam logic [15:0] BLOCK_OFFSET_MASK = 16'h000F;
    localparam logic        FILL_SEL_I        = 1'b0;
    localparam logic        FILL_SEL_D        = 1'b1;

    function automatic logic [15:0] block_base(input logic [15:0] addr);
        return addr & ~BLOCK_OFFSET_MASK;
    endfunction

    // Word index is added as a byte offset; a block-aligned base never carries out.
    function automatic logic [15:0] word_addr(input logic [15:0] base, input logic [2:0] idx);
        return base + {12'h000, idx, 1'b0};
    endfunction

endpackage

// File: rtl/cache_fill_arbiter_fill_counter.sv
// Three-bit word counter with synchronous clear, count enable and a
// terminal flag raised on the last word of a block.
module fill_counter
    import cache_fill_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    output logic [2:0] cnt,
    output logic       last
);

    logic [2:0] cnt_r;

    // Word counter register; clear has priority over enable.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r <= 3'd0;
        end else if (clr) begin
            cnt_r <= 3'd0;
        end else if (en) begin
            cnt_r <= cnt_r + 3'd1;
        end
    end

    assign cnt  = cnt_r;
    assign last = (cnt_r == 3'(WORDS_PER_BLOCK - 1));

endmodule

// File: rtl/cache_fill_arbiter.sv
// Block-fill controller shared by the I- and D-caches. Optional round-robin
// grant is enabled with the CACHE_ARB_RR_EN macro (default: D over I).
module cache_fill_arbiter
    import cache_fill_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_miss,
    input  logic [15:0] i_miss_addr,
    input  logic        d_miss,
    input  logic [15:0] d_miss_addr,
    input  logic [15:0] mem_data,
    input  logic        mem_data_valid,
    output logic [15:0] mem_addr,
    output logic        mem_en,
    output logic        fill_wen,
    output logic        fill_sel,
    output logic [2:0]  fill_word,
    output logic [15:0] fill_data,
    output logic [15:0] fill_addr,
    output logic        fill_tag_wen,
    output logic        i_fill_done,
    output logic        d_fill_done,
    output logic        i_stall,
    output logic        d_stall
);

    fill_state_t state_r;
    fill_state_t next_state_s;
    logic        fill_sel_r;
    logic [15:0] fill_addr_r;
    logic        issue_done_r;
    logic        grant_sel_s;
    logic        take_grant_s;
    logic        cnt_clr_s;
    logic        issuing_s;
    logic        receiving_s;
    logic        busy_s;
    logic [2:0]  issue_cnt_s;
    logic [2:0]  recv_cnt_s;
    logic        issue_last_s;
    logic        recv_last_s;

    assign busy_s       = (state_r != IDLE);
    assign cnt_clr_s    = (state_r != FILL);
    assign issuing_s    = (state_r == FILL) && !issue_done_r;
    assign receiving_s  = (state_r == FILL) && mem_data_valid;
    assign take_grant_s = (state_r == IDLE) && (i_miss || d_miss);

    fill_counter u_issue_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr_s),
        .en    (issuing_s),
        .cnt   (issue_cnt_s),
        .last  (issue_last_s)
    );

    fill_counter u_recv_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr_s),
        .en    (receiving_s),
        .cnt   (recv_cnt_s),
        .last  (recv_last_s)
    );

`ifdef CACHE_ARB_RR_EN
    logic last_grant_r;

    // Remembers the most recent grant so a contested miss alternates.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant_r <= FILL_SEL_I;
        end else if (take_grant_s) begin
            last_grant_r <= grant_sel_s;
        end
    end

    // Round-robin grant: on contention the requester not granted last wins.
    always_comb begin
        grant_sel_s = FILL_SEL_I;
        if (i_miss && d_miss) begin
            grant_sel_s = ~last_grant_r;
        end else if (d_miss) begin
            grant_sel_s = FILL_SEL_D;
        end else begin
            grant_sel_s = FILL_SEL_I;
        end
    end
`else
    // Fixed grant: the D miss belongs to the older instruction.
    always_comb begin
        grant_sel_s = FILL_SEL_I;
        if (d_miss) begin
            grant_sel_s = FILL_SEL_D;
        end else begin
            grant_sel_s = FILL_SEL_I;
        end
    end
`endif

    // State, grant target and issue-complete flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            fill_sel_r   <= FILL_SEL_I;
            fill_addr_r  <= 16'h0000;
            issue_done_r <= 1'b0;
        end else begin
            state_r <= next_state_s;
            if (take_grant_s) begin
                fill_sel_r  <= grant_sel_s;
                fill_addr_r <= block_base(grant_sel_s ? d_miss_addr : i_miss_addr);
            end
            if (cnt_clr_s) begin
                issue_done_r <= 1'b0;
            end else if (issuing_s && issue_last_s) begin
                issue_done_r <= 1'b1;
            end
        end
    end

    // Next state and the per-state memory / cache strobes.
    always_comb begin
        next_state_s = state_r;
        mem_en       = 1'b0;
        mem_addr     = 16'h0000;
        fill_wen     = 1'b0;
        fill_word    = 3'd0;
        fill_data    = 16'h0000;
        fill_tag_wen = 1'b0;
        i_fill_done  = 1'b0;
        d_fill_done  = 1'b0;
        case (state_r)
            IDLE: begin
                if (i_miss || d_miss) begin
                    next_state_s = FILL;
                end else begin
                    next_state_s = IDLE;
                end
            end
            FILL: begin
                mem_en = issuing_s;
                if (issuing_s) begin
                    mem_addr = word_addr(fill_addr_r, issue_cnt_s);
                end else begin
                    mem_addr = 16'h0000;
                end
                if (mem_data_valid) begin
                    fill_wen  = 1'b1;
                    fill_word = recv_cnt_s;
                    fill_data = mem_data;
                end else begin
                    fill_wen  = 1'b0;
                end
                if (mem_data_valid && recv_last_s) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = FILL;
                end
            end
            DONE: begin
                fill_tag_wen = 1'b1;
                i_fill_done  = (fill_sel_r == FILL_SEL_I);
                d_fill_done  = (fill_sel_r == FILL_SEL_D);
                next_state_s = IDLE;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    assign fill_sel  = fill_sel_r;
    assign fill_addr = fill_addr_r;
    assign i_stall   = i_miss | (busy_s & (fill_sel_r == FILL_SEL_I));
    assign d_stall   = d_miss | (busy_s & (fill_sel_r == FILL_SEL_D));

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Directed bench for cache_fill_arbiter with a 4-cycle pipelined memory
// model returning addr^16'hA5A5 and a transaction-level reference model.
module tb_cache_fill_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_miss, d_miss;
    logic [15:0] i_miss_addr, d_miss_addr;
    logic [15:0] mem_data;
    logic        mem_data_valid;
    logic [15:0] mem_addr;
    logic        mem_en, fill_wen, fill_sel, fill_tag_wen;
    logic [2:0]  fill_word;
    logic [15:0] fill_data, fill_addr;
    logic        i_fill_done, d_fill_done, i_stall, d_stall;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    cache_fill_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .i_miss(i_miss), .i_miss_addr(i_miss_addr),
        .d_miss(d_miss), .d_miss_addr(d_miss_addr),
        .mem_data(mem_data), .mem_data_valid(mem_data_valid),
        .mem_addr(mem_addr), .mem_en(mem_en),
        .fill_wen(fill_wen), .fill_sel(fill_sel), .fill_word(fill_word),
        .fill_data(fill_data), .fill_addr(fill_addr), .fill_tag_wen(fill_tag_wen),
        .i_fill_done(i_fill_done), .d_fill_done(d_fill_done),
        .i_stall(i_stall), .d_stall(d_stall)
    );

    always #5 clk = ~clk;

    task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %b expected %b", nm, cyc, act, exp);
        end
    endtask

    // Reference model: one outstanding fill described by its target, base,
    // words issued, words received and whether the completion cycle is due.
    logic        m_busy = 1'b0, m_done = 1'b0, m_sel = 1'b0, m_last = 1'b0;
    logic [15:0] m_base = 16'h0;
    int          m_iss = 0, m_rcv = 0;
    logic        chk_en = 1'b0;

    function automatic logic pick(input logic im, input logic dm, input logic last);
`ifdef CACHE_ARB_RR_EN
        if (im && dm) return ~last;
`endif
        return dm;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_sel <= 1'b0; m_last <= 1'b0;
            m_base <= 16'h0; m_iss <= 0; m_rcv <= 0; chk_en <= 1'b1;
        end else if (!m_busy) begin
            if (i_miss || d_miss) begin
                m_busy <= 1'b1;
                m_sel  <= pick(i_miss, d_miss, m_last);
                m_last <= pick(i_miss, d_miss, m_last);
                m_base <= (pick(i_miss, d_miss, m_last) ? d_miss_addr : i_miss_addr) & 16'hFFF0;
                m_iss  <= 0;
                m_rcv  <= 0;
            end
        end else if (m_done) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
        end else begin
            if (m_iss < 8) m_iss <= m_iss + 1;
            if (mem_data_valid) begin
                m_rcv <= m_rcv + 1;
                if (m_rcv == 7) m_done <= 1'b1;
            end
        end
    end

    logic        e_en, e_wen;
    logic [15:0] e_addr, e_data;
    logic [2:0]  e_word;
    always_comb begin
        e_en   = m_busy && !m_done && (m_iss < 8);
        e_addr = e_en ? m_base + 16'(2 * m_iss) : 16'h0000;
        e_wen  = m_busy && !m_done && mem_data_valid;
        e_word = e_wen ? 3'(m_rcv) : 3'd0;
        e_data = e_wen ? mem_data : 16'h0000;
    end

    // Every-cycle comparison against the model, mid-cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            chk1 ("mem_en",       mem_en,       e_en);
            chk16("mem_addr",     mem_addr,     e_addr);
            chk1 ("fill_wen",     fill_wen,     e_wen);
            chk16("fill_word",    16'(fill_word), 16'(e_word));
            chk16("fill_data",    fill_data,    e_data);
            chk1 ("fill_sel",     fill_sel,     m_sel);
            chk16("fill_addr",    fill_addr,    m_base);
            chk1 ("fill_tag_wen", fill_tag_wen, m_done);
            chk1 ("i_fill_done",  i_fill_done,  m_done && !m_sel);
            chk1 ("d_fill_done",  d_fill_done,  m_done && m_sel);
            chk1 ("i_stall",      i_stall,      i_miss | (m_busy & !m_sel));
            chk1 ("d_stall",      d_stall,      d_miss | (m_busy & m_sel));
        end
    end

    // Stimulus requests, applied just after the next rising edge.
    logic        i_req = 1'b0, d_req = 1'b0, rst_req = 1'b1, spur = 1'b0;
    logic [15:0] ia = 16'h0, da = 16'h0;
    logic [3:0]  pv = 4'h0;
    logic [15:0] pa [4];

    task automatic step();
        @(posedge clk);
        #1;
        rst_n          = ~rst_req;
        i_miss         = i_req;
        d_miss         = d_req;
        i_miss_addr    = ia;
        d_miss_addr    = da;
        mem_data_valid = pv[3] | spur;
        mem_data       = pv[3] ? (pa[3] ^ 16'hA5A5) : (spur ? 16'h5A5A : 16'h0000);
        cyc++;
        @(negedge clk);
        pv    = {pv[2:0], mem_en};
        pa[3] = pa[2]; pa[2] = pa[1]; pa[1] = pa[0]; pa[0] = mem_addr;
    endtask

    int  wen_cnt;
    logic first_sel;

    initial begin
        rst_n = 1'b0; i_miss = 1'b0; d_miss = 1'b0;
        i_miss_addr = 16'h0; d_miss_addr = 16'h0;
        mem_data = 16'h0; mem_data_valid = 1'b0;
        for (int k = 0; k < 4; k++) pa[k] = 16'h0;
        step(); step();
        chk1 ("rst_mem_en", mem_en, 1'b0);
        chk16("rst_fill_addr", fill_addr, 16'h0000);
        rst_req = 1'b0;
        step(); step();

        // Single I miss at 0x0126.
        ia = 16'h0126; i_req = 1'b1; cyc = -1; wen_cnt = 0;
        for (int k = 0; k < 15; k++) begin
            step();
            if (cyc >= 1 && cyc <= 8) chk16("t1_mem_addr", mem_addr, 16'h0120 + 16'(2 * (cyc - 1)));
            if (fill_wen) wen_cnt++;
            if (cyc == 5) chk16("t1_word0_data", fill_data, 16'hA485);
            if (cyc == 12) begin
                chk16("t1_word7_idx", 16'(fill_word), 16'h0007);
                chk16("t1_word7_data", fill_data, 16'hA48B);
            end
            if (cyc == 13) begin
                chk1 ("t1_tag_wen", fill_tag_wen, 1'b1);
                chk16("t1_fill_addr", fill_addr, 16'h0120);
                chk1 ("t1_i_done", i_fill_done, 1'b1);
                i_req = 1'b0;
            end
            if (cyc == 14) chk1("t1_i_stall_idle", i_stall, 1'b0);
        end
        chk16("t1_wen_count", 16'(wen_cnt), 16'd8);

        // Simultaneous I (0x0040) and D (0x8000) misses.
        ia = 16'h0040; da = 16'h8000; i_req = 1'b1; d_req = 1'b1; cyc = -1;
        for (int k = 0; k < 29; k++) begin
            step();
            if (cyc == 1) begin
                chk1 ("t2_first_sel", fill_sel, 1'b1);
                chk16("t2_first_addr", mem_addr, 16'h8000);
                chk1 ("t2_i_stall", i_stall, 1'b1);
                chk1 ("t2_d_stall", d_stall, 1'b1);
            end
            if (cyc == 13) begin chk1("t2_d_done", d_fill_done, 1'b1); d_req = 1'b0; end
            if (cyc == 14) chk1("t2_idle_no_issue", mem_en, 1'b0);
            if (cyc == 15) begin
                chk1 ("t2_i_issue", mem_en, 1'b1);
                chk16("t2_i_addr", mem_addr, 16'h0040);
            end
            if (cyc == 27) begin chk1("t2_i_done", i_fill_done, 1'b1); i_req = 1'b0; end
        end

        // D miss at the top of memory.
        da = 16'hFFFE; d_req = 1'b1; cyc = -1;
        for (int k = 0; k < 15; k++) begin
            step();
            if (cyc >= 1 && cyc <= 8) chk16("t3_mem_addr", mem_addr, 16'hFFF0 + 16'(2 * (cyc - 1)));
            if (cyc == 8) chk16("t3_last_addr", mem_addr, 16'hFFFE);
            if (cyc == 13) begin
                chk16("t3_fill_addr", fill_addr, 16'hFFF0);
                chk1 ("t3_d_done", d_fill_done, 1'b1);
                d_req = 1'b0;
            end
        end

        // Second simultaneous pair, after a D-only fill.
`ifdef CACHE_ARB_RR_EN
        first_sel = 1'b0;
`else
        first_sel = 1'b1;
`endif
        ia = 16'h0300; da = 16'h0500; i_req = 1'b1; d_req = 1'b1; cyc = -1;
        for (int k = 0; k < 29; k++) begin
            step();
            if (cyc == 1) chk1("t4_first_sel", fill_sel, first_sel);
            if (cyc == 13) begin
                if (first_sel) d_req = 1'b0; else i_req = 1'b0;
            end
            if (cyc == 27) begin i_req = 1'b0; d_req = 1'b0; end
        end

        // I miss withdrawn in cycle 3 still completes.
        ia = 16'h0A10; i_req = 1'b1; cyc = -1; wen_cnt = 0;
        for (int k = 0; k < 15; k++) begin
            step();
            if (cyc == 2) i_req = 1'b0;
            if (fill_wen) wen_cnt++;
            if (cyc == 5) chk1("t5_i_stall_busy", i_stall, 1'b1);
            if (cyc == 13) begin
                chk1("t5_tag_wen", fill_tag_wen, 1'b1);
                chk1("t5_i_done", i_fill_done, 1'b1);
            end
        end
        chk16("t5_wen_count", 16'(wen_cnt), 16'd8);

        // Reset in cycle 6 of a fill.
        ia = 16'h1234; i_req = 1'b1; cyc = -1; wen_cnt = 0;
        for (int k = 0; k < 15; k++) begin
            step();
            if (cyc == 5) begin rst_req = 1'b1; i_req = 1'b0; end
            if (cyc == 6) rst_req = 1'b0;
            if (cyc == 7) begin
                chk1 ("t6_mem_en", mem_en, 1'b0);
                chk16("t6_mem_addr", mem_addr, 16'h0000);
                chk1 ("t6_fill_sel", fill_sel, 1'b0);
                chk16("t6_fill_addr", fill_addr, 16'h0000);
                chk16("t6_fill_data", fill_data, 16'h0000);
                chk1 ("t6_late_beat", mem_data_valid, 1'b1);
                chk1 ("t6_i_stall", i_stall, 1'b0);
            end
            if (cyc >= 7 && fill_wen) wen_cnt++;
        end
        chk16("t6_wen_after_reset", 16'(wen_cnt), 16'd0);

        // Spurious valid beats while idle.
        spur = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk1("t7_no_wen", fill_wen, 1'b0);
            chk1("t7_no_issue", mem_en, 1'b0);
        end
        spur = 1'b0;
        step(); step();
        chk1("t7_still_idle", mem_en, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
